dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/instr_pack.sv | 18 +
 rtl/dmem_array.sv | 40 ++++
 rtl/dmem_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - shared FSM type and defaults for the data-memory responder
package instr_pack;

  localparam int DMEM_ADDR_W_DEF = 8;
  localparam int DMEM_RD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } dmem_state_e;

  // Number of RD_WAIT cycles for a load; one more when the write buffer must drain first.
  function automatic logic [2:0] rd_wait_cycles(input int rd_lat, input logic drain_first);
    return 3'(rd_lat - 1) + 3'(drain_first);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port byte array with an RD_LAT-cycle registered read
module dmem_array
  import instr_pack::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W_DEF,
  parameter int RD_LAT = DMEM_RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem_q  [DEPTH];
  logic [7:0] pipe_q [RD_LAT];

  // Write port; array contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read pipeline: stage 0 samples the array, later stages stretch it to RD_LAT cycles.
  always_ff @(posedge clk) begin
    if (en_i && !we_i) begin
      pipe_q[0] <= mem_q[addr_i];
    end
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign rdata_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with one-entry write buffer; DMEM_STORE_FWD_EN enables store-to-load forwarding
module dmem_responder
  import instr_pack::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W_DEF,
  parameter int RD_LAT = DMEM_RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loadEn,
  input  logic              storEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        storData,
  output logic [7:0]        loadData,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  dmem_state_e       state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              fwd_q, fwd_d;
  logic [7:0]        fwd_data_q, fwd_data_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [7:0]        wb_data_q, wb_data_d;
  logic              st_ack_q, st_ack_d;
  logic              err_q, err_d;
  logic [7:0]        load_data_q, load_data_d;

  logic              req_acc, st_acc, ld_acc, fwd_hit, drain, rd_now, rd_late;
  logic [2:0]        wait_n;
  logic              arr_en, arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [7:0]        arr_rdata, done_data;

`ifdef DMEM_STORE_FWD_EN
  assign fwd_hit = wb_valid_q && (addr == wb_addr_q);
`else
  assign fwd_hit = 1'b0;
`endif

  // A simultaneous load+store is treated as a store only.
  assign req_acc = (loadEn || storEn) && (state_q == IDLE);
  assign st_acc  = req_acc && storEn;
  assign ld_acc  = req_acc && loadEn && !storEn;

  // The buffer drains whenever the port is free; a non-forwarded load hitting a full
  // buffer drains at acceptance and issues its read one cycle later.
  assign drain   = wb_valid_q && ((state_q == RD_DONE) ||
                                  ((state_q == IDLE) && !(ld_acc && fwd_hit)));
  assign rd_now  = ld_acc && !fwd_hit && !wb_valid_q;
  assign rd_late = (state_q == RD_WAIT) && rd_pend_q;
  assign wait_n  = rd_wait_cycles(RD_LAT, wb_valid_q);

  assign arr_en   = drain || rd_now || rd_late;
  assign arr_we   = drain;
  assign arr_addr = drain ? wb_addr_q : (rd_late ? addr_q : addr);

  dmem_array #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_array (
    .clk     (clk),
    .en_i    (arr_en),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .wdata_i (wb_data_q),
    .rdata_o (arr_rdata)
  );

  assign done_data = fwd_q ? fwd_data_q : arr_rdata;
  assign loadData  = (state_q == RD_DONE) ? done_data : load_data_q;
  assign ack       = st_ack_q || (state_q == RD_DONE);
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

  // Next-state logic for the FSM, write buffer and sticky error.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rd_pend_d   = rd_pend_q;
    fwd_d       = fwd_q;
    fwd_data_d  = fwd_data_q;
    wb_valid_d  = wb_valid_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    st_ack_d    = st_acc;
    err_d       = err_q;
    load_data_d = load_data_q;

    if (drain) begin
      wb_valid_d = 1'b0;
    end
    if (st_acc) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = addr;
      wb_data_d  = storData;
      if (loadEn) begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (ld_acc) begin
          addr_d     = addr;
          fwd_d      = fwd_hit;
          fwd_data_d = wb_data_q;
          rd_pend_d  = wb_valid_q && !fwd_hit;
          cnt_d      = wait_n;
          if (fwd_hit || (wait_n == 3'd0)) begin
            state_d = RD_DONE;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        rd_pend_d = 1'b0;
        if (cnt_q <= 3'd1) begin
          state_d = RD_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RD_DONE: begin
        load_data_d = done_data;
        fwd_d       = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any load and discards the buffered store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      addr_q      <= '0;
      rd_pend_q   <= 1'b0;
      fwd_q       <= 1'b0;
      fwd_data_q  <= 8'd0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= 8'd0;
      st_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rd_pend_q   <= rd_pend_d;
      fwd_q       <= fwd_d;
      fwd_data_q  <= fwd_data_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      st_ack_q    <= st_ack_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

endmodule
